// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide sequencer: state encoding and timing constants.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_sched_if.sv
// Decode/EX-side handshake and HI/LO write bus of the divide sequencer.
interface div_sched_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             hilo_access;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             complete;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;

  modport master (
    output start, div_signed, dividend, divisor, hilo_access, flush,
    input  busy, stall, complete, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, div_signed, dividend, divisor, hilo_access, flush,
    output busy, stall, complete, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // One extra bit so the shifted remainder never overflows before the compare.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  always_comb begin
    o_rem = w_shift[WIDTH-1:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_sched.sv
// Iterative HI/LO divide sequencer: magnitude divide over WIDTH cycles, sign fix-up, ID stall.
module div_sched
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        reset,
  div_sched_if.slave bus
);
  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_neg_dvd;
  logic             r_neg_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_rem),
    .o_quo     (w_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_neg_dvd <= 1'b0;
      r_neg_dvs <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
    end else if (bus.flush && r_state != IDLE) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            r_state   <= PREP;
            r_signed  <= bus.div_signed;
            r_neg_dvd <= bus.dividend[WIDTH-1];
            r_neg_dvs <= bus.divisor[WIDTH-1];
            r_quo     <= bus.dividend;
            r_dvsr    <= bus.divisor;
          end
        end
        PREP: begin
          // The quotient register carries the dividend magnitude until it is shifted out.
          if (r_signed && r_neg_dvd) r_quo <= -r_quo;
          if (r_signed && r_neg_dvs) r_dvsr <= -r_dvsr;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_signed && (r_neg_dvd ^ r_neg_dvs)) r_quo <= -r_quo;
          if (r_signed && r_neg_dvd) r_rem <= -r_rem;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A flush landing on DONE must kill the HI/LO write in the same cycle.
  assign bus.busy     = (r_state != IDLE);
  assign bus.stall    = bus.busy & (bus.hilo_access | bus.start);
  assign bus.complete = (r_state == DONE) & ~bus.flush;
  assign bus.hi_we    = bus.complete;
  assign bus.lo_we    = bus.complete;
  assign bus.hi_wdata = r_rem;
  assign bus.lo_wdata = r_quo;
endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched: latency, signed/unsigned results, stall, flush, reset.
module tb_div_sched;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div_sched_if #(.WIDTH(32)) bus ();

  div_sched #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int lat;
    bus.start      = 1'b1;
    bus.div_signed = sg;
    bus.dividend   = a;
    bus.divisor    = b;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (bus.complete !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd35);
    chk({tag, "_quotient"}, bus.lo_wdata, q);
    chk({tag, "_remainder"}, bus.hi_wdata, r);
    chk({tag, "_hi_we"}, {31'd0, bus.hi_we}, 32'd1);
    chk({tag, "_lo_we"}, {31'd0, bus.lo_we}, 32'd1);
    $display("div %s signed=%0d a=%h b=%h q=%h r=%h latency=%0d",
             tag, sg, a, b, bus.lo_wdata, bus.hi_wdata, lat);
    tick();
    chk({tag, "_complete_drop"}, {31'd0, bus.complete}, 32'd0);
    chk({tag, "_we_drop"}, {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start       = 1'b0;
    bus.div_signed  = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    bus.hilo_access = 1'b0;
    bus.flush       = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_complete", {31'd0, bus.complete}, 32'd0);
    chk("rst_we", {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    chk("rst_hi_wdata", bus.hi_wdata, 32'd0);
    chk("rst_lo_wdata", bus.lo_wdata, 32'd0);
    reset = 1'b0;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    run_div("divu_7_0", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);

    // Stall hazard with an ignored second start at cycle 10.
    bus.start      = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      bus.hilo_access = (c >= 5 && c <= 36);
      bus.start       = (c == 10);
      #1;
      if (bus.complete === 1'b1) pulses++;
      if (c >= 5 && c <= 36)
        chk($sformatf("hazard_stall_c%0d", c), {31'd0, bus.stall}, (c <= 35) ? 32'd1 : 32'd0);
    end
    bus.hilo_access = 1'b0;
    bus.start       = 1'b0;
    chk("hazard_single_pulse", 32'(pulses), 32'd1);
    chk("hazard_idle_after", {31'd0, bus.busy}, 32'd0);
    $display("hazard run complete_pulses=%0d", pulses);
    tick();

    // Flush mid-RUN, then an immediate new divide.
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (bus.complete === 1'b1) pulses++;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_run_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_run_no_complete", {31'd0, bus.complete} + 32'(pulses), 32'd0);
    $display("flush mid-run busy=%0d pulses=%0d", bus.busy, pulses);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Flush and start together in IDLE: nothing starts.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flush_start_idle", {31'd0, bus.busy}, 32'd0);
    $display("flush+start in idle busy=%0d", bus.busy);

    // Flush landing on the DONE cycle.
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 35; c++) tick();
    chk("done_busy_before_flush", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_done_complete", {31'd0, bus.complete}, 32'd0);
    chk("flush_done_we", {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_done_idle", {31'd0, bus.busy}, 32'd0);
    $display("flush in done complete suppressed busy=%0d", bus.busy);

    // Reset mid-RUN clears everything.
    bus.start       = 1'b1;
    bus.dividend    = 32'd1234;
    bus.divisor     = 32'd11;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    bus.hilo_access = 1'b1;
    reset = 1'b1;
    tick();
    chk("rstrun_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstrun_stall", {31'd0, bus.stall}, 32'd0);
    chk("rstrun_complete", {31'd0, bus.complete}, 32'd0);
    chk("rstrun_we", {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    chk("rstrun_hi_wdata", bus.hi_wdata, 32'd0);
    chk("rstrun_lo_wdata", bus.lo_wdata, 32'd0);
    $display("reset mid-run busy=%0d lo=%h hi=%h", bus.busy, bus.lo_wdata, bus.hi_wdata);
    reset = 1'b0;
    bus.hilo_access = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
